// File: rtl/score_pkg.sv
// Shared encodings and the note-slot record used by the score pixel generator.
package score_pkg;

  typedef enum logic [1:0] {
    PIX_NOTE   = 2'd0,
    PIX_STAFF  = 2'd1,
    PIX_CURSOR = 2'd2,
    PIX_BG     = 2'd3
  } pix_type_e;

  typedef enum logic [1:0] {
    INSTR_RED   = 2'd0,
    INSTR_GREEN = 2'd1,
    INSTR_BLUE  = 2'd2,
    INSTR_WHITE = 2'd3
  } instr_e;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned V_ACTIVE_DEF = 720;

  typedef struct packed {
    logic       on;
    logic [3:0] pitch;
    logic [1:0] instr;
  } note_slot_t;

endpackage

// File: rtl/note_store.sv
// Per-column note register array with a single write port, global clear and
// one registered read port.
module note_store
  import score_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 16,
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_en_in,
  input  logic [SLOT_W-1:0] wr_slot_in,
  input  logic              wr_on_in,
  input  logic [3:0]        wr_pitch_in,
  input  logic [1:0]        wr_instr_in,
  input  logic              clear_in,
  input  logic [SLOT_W-1:0] rd_slot_in,
  output logic              rd_on_out,
  output logic [3:0]        rd_pitch_out,
  output logic [1:0]        rd_instr_out
);

  note_slot_t [NUM_SLOTS-1:0] slots_d, slots_q;
  note_slot_t                 rd_d, rd_q;

  // Clear wins over a same-cycle write; only the on flags are dropped.
  always_comb begin
    slots_d = slots_q;
    if (clear_in) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slots_d[SLOT_W'(i)].on = 1'b0;
      end
    end else if (wr_en_in) begin
      slots_d[wr_slot_in] = '{on: wr_on_in, pitch: wr_pitch_in, instr: wr_instr_in};
    end
    rd_d = slots_q[rd_slot_in];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slots_q <= '0;
      rd_q    <= '0;
    end else begin
      slots_q <= slots_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_on_out    = rd_q.on;
  assign rd_pitch_out = rd_q.pitch;
  assign rd_instr_out = rd_q.instr;

endmodule

// File: rtl/score_pixel_gen.sv
// Two-stage pixel classifier: staff lines, stored notes and a tempo-driven
// playback cursor; the note store is writable only during vertical blanking.
module score_pixel_gen
  import score_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 16,
  parameter int unsigned NOTE_W       = 32,
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned STAFF_TOP    = 200,
  parameter int unsigned LINE_SPACING = 16,
  parameter int unsigned NOTE_H       = 8,
  parameter int unsigned TEMPO_FRAMES = 30,
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  input  logic [SLOT_W-1:0] wr_slot_in,
  input  logic [3:0]        wr_pitch_in,
  input  logic [1:0]        wr_instr_in,
  input  logic              wr_on_in,
  input  logic              clear_in,
  input  logic              pause_in,
  output logic [1:0]        pixel_type_out,
  output logic [1:0]        instrument_type_out,
  output logic              pixel_valid_out,
  output logic [SLOT_W-1:0] cursor_col_out
);

  localparam int unsigned OFF_W = $clog2(NOTE_W);
  localparam int unsigned CNT_W = $clog2(TEMPO_FRAMES + 1);

  localparam logic [10:0]        H_ACT     = 11'(H_ACTIVE);
  localparam logic [9:0]         V_ACT     = 10'(V_ACTIVE);
  localparam logic [10:0]        SPAN_X    = 11'(NUM_SLOTS * NOTE_W);
  localparam logic [9:0]         STAFF_Y0  = 10'(STAFF_TOP);
  localparam logic [9:0]         STAFF_Y1  = 10'(STAFF_TOP + 4 * LINE_SPACING);
  localparam logic [OFF_W-1:0]   OFF_LO    = OFF_W'(2);
  localparam logic [OFF_W-1:0]   OFF_HI    = OFF_W'(NOTE_W - 3);
  localparam logic signed [10:0] TOP_S     = 11'(STAFF_TOP);
  localparam logic signed [10:0] HALF_SP_S = 11'(LINE_SPACING / 2);
  localparam logic signed [10:0] HALF_NH_S = 11'(NOTE_H / 2);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TEMPO_FRAMES - 1);

  // Write port
  logic wr_ready_d, wr_ready_q;
  logic wr_en;

  always_comb begin
    wr_ready_d = (vcount_in >= V_ACT) && !clear_in;
    wr_en      = wr_valid_in && wr_ready_q;
  end

  // Frame tick and cursor
  logic              tick;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [SLOT_W-1:0] cursor_d, cursor_q;

  always_comb begin
    tick     = (hcount_in == '0) && (vcount_in == V_ACT);
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    if (tick && !pause_in) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        cursor_d = cursor_q + SLOT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1: coordinates, active flag and cursor-column match; store read in parallel.
  logic [SLOT_W-1:0] slot_in;
  logic [10:0]       x_d, x_q;
  logic [9:0]        y_d, y_q;
  logic              act_d, act_q;
  logic              cur_hit_d, cur_hit_q;

  always_comb begin
    slot_in   = hcount_in[OFF_W +: SLOT_W];
    x_d       = hcount_in;
    y_d       = vcount_in;
    act_d     = (hcount_in < H_ACT) && (vcount_in < V_ACT);
    cur_hit_d = (slot_in == cursor_q);
  end

  logic       rd_on;
  logic [3:0] rd_pitch;
  logic [1:0] rd_instr;

  note_store #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_store (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_en_in    (wr_en),
    .wr_slot_in  (wr_slot_in),
    .wr_on_in    (wr_on_in),
    .wr_pitch_in (wr_pitch_in),
    .wr_instr_in (wr_instr_in),
    .clear_in    (clear_in),
    .rd_slot_in  (slot_in),
    .rd_on_out   (rd_on),
    .rd_pitch_out(rd_pitch),
    .rd_instr_out(rd_instr)
  );

  // Stage 2: classify
  logic [OFF_W-1:0]   off;
  logic               in_x, in_staff, on_line, note_hit;
  logic signed [10:0] note_dy;
  pix_type_e          pix_type_d, pix_type_q;
  logic [1:0]         instr_d, instr_q;
  logic               valid_d, valid_q;

  always_comb begin
    off      = x_q[OFF_W-1:0];
    in_x     = x_q < SPAN_X;
    in_staff = in_x && (y_q >= STAFF_Y0) && (y_q <= STAFF_Y1);
    on_line  = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      if (y_q == 10'(STAFF_TOP + k * LINE_SPACING)) on_line = 1'b1;
    end
    note_dy  = $signed({1'b0, y_q}) - (TOP_S + $signed({7'd0, rd_pitch}) * HALF_SP_S);
    note_hit = rd_on && in_x && (off >= OFF_LO) && (off <= OFF_HI) &&
               (note_dy > -HALF_NH_S) && (note_dy < HALF_NH_S);

    pix_type_d = PIX_BG;
    instr_d    = INSTR_RED;
    valid_d    = act_q;
    if (act_q) begin
      if (note_hit) begin
        pix_type_d = PIX_NOTE;
        instr_d    = rd_instr;
      end else if (cur_hit_q && (off < OFF_LO) && in_staff) begin
        pix_type_d = PIX_CURSOR;
      end else if (on_line && in_staff) begin
        pix_type_d = PIX_STAFF;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ready_q <= 1'b0;
      cnt_q      <= '0;
      cursor_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      act_q      <= 1'b0;
      cur_hit_q  <= 1'b0;
      pix_type_q <= PIX_BG;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      wr_ready_q <= wr_ready_d;
      cnt_q      <= cnt_d;
      cursor_q   <= cursor_d;
      x_q        <= x_d;
      y_q        <= y_d;
      act_q      <= act_d;
      cur_hit_q  <= cur_hit_d;
      pix_type_q <= pix_type_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign wr_ready_out        = wr_ready_q;
  assign cursor_col_out      = cursor_q;
  assign pixel_type_out      = pix_type_q;
  assign instrument_type_out = instr_q;
  assign pixel_valid_out     = valid_q;

endmodule

// File: tb/tb_score_pixel_gen.sv
// Bench for score_pixel_gen: randomized scan coordinates and note writes against
// an arithmetic reference model, plus hand-computed directed expectations.
module tb_score_pixel_gen;

  localparam int TEMPO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        wr_valid, wr_ready, wr_on, clear, pause;
  logic [3:0]  wr_slot, wr_pitch, cursor;
  logic [1:0]  wr_instr, ptype, itype;
  logic        pvalid;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  score_pixel_gen #(.TEMPO_FRAMES(TEMPO)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .hcount_in          (hcount),
    .vcount_in          (vcount),
    .wr_valid_in        (wr_valid),
    .wr_ready_out       (wr_ready),
    .wr_slot_in         (wr_slot),
    .wr_pitch_in        (wr_pitch),
    .wr_instr_in        (wr_instr),
    .wr_on_in           (wr_on),
    .clear_in           (clear),
    .pause_in           (pause),
    .pixel_type_out     (ptype),
    .instrument_type_out(itype),
    .pixel_valid_out    (pvalid),
    .cursor_col_out     (cursor)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_on[16], m_pitch[16], m_instr[16];
  int m_cursor, m_cnt, m_ready;
  int st_t, st_i, st_v;
  int out_t, out_i, out_v;

  function automatic void classify(input int x, input int y, output int t, output int ins, output int v);
    int  slot, off, dy;
    bit  in_x, span;
    t = 3; ins = 0; v = 0;
    if (x < 1280 && y < 720) begin
      v    = 1;
      slot = x / 32;
      off  = x % 32;
      in_x = (x < 16 * 32);
      span = in_x && y >= 200 && y <= 200 + 4 * 16;
      dy   = in_x ? y - (200 + m_pitch[slot] * 8) : 1000;
      if (in_x && m_on[slot] != 0 && off >= 2 && off <= 29 && dy > -4 && dy < 4) begin
        t = 0; ins = m_instr[slot];
      end else if (span && slot == m_cursor && off < 2) begin
        t = 2;
      end else if (span && (y - 200) % 16 == 0) begin
        t = 1;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int t, i, v;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_on[k] <= 0; m_pitch[k] <= 0; m_instr[k] <= 0;
      end
      m_cursor <= 0; m_cnt <= 0; m_ready <= 0;
      st_t <= 3; st_i <= 0; st_v <= 0;
      out_t <= 3; out_i <= 0; out_v <= 0;
    end else begin
      out_t <= st_t; out_i <= st_i; out_v <= st_v;
      classify(int'(hcount), int'(vcount), t, i, v);
      st_t <= t; st_i <= i; st_v <= v;
      if (clear) begin
        for (int k = 0; k < 16; k++) m_on[k] <= 0;
      end else if (wr_valid && m_ready != 0) begin
        m_on[wr_slot]    <= int'(wr_on);
        m_pitch[wr_slot] <= int'(wr_pitch);
        m_instr[wr_slot] <= int'(wr_instr);
      end
      m_ready <= (int'(vcount) >= 720 && !clear) ? 1 : 0;
      if (hcount == 11'd0 && vcount == 10'd720 && !pause) begin
        if (m_cnt + 1 == TEMPO) begin
          m_cnt    <= 0;
          m_cursor <= (m_cursor + 1) % 16;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model pixel_type", int'(ptype), out_t);
      cmp("model instrument", int'(itype), out_i);
      cmp("model valid", int'(pvalid), out_v);
      cmp("model wr_ready", int'(wr_ready), m_ready);
      cmp("model cursor", int'(cursor), m_cursor);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic px(input int x, input int y);
    hcount = 11'(x);
    vcount = 10'(y);
  endtask

  task automatic probe(input string name, input int x, input int y, input int et, input int ei);
    px(x, y);
    step();
    px(1400, 730);
    step();
    cmp({name, " type"}, int'(ptype), et);
    cmp({name, " instr"}, int'(itype), ei);
  endtask

  task automatic write_note(input int slot, input int pitch, input int instr, input int on);
    wr_slot  = 4'(slot);
    wr_pitch = 4'(pitch);
    wr_instr = 2'(instr);
    wr_on    = 1'(on);
    wr_valid = 1'b1;
  endtask

  task automatic tick_frame();
    px(0, 720);
    step();
    px(5, 730);
    step();
  endtask

  initial begin
    int r;
    rst = 1'b1; px(0, 0);
    wr_valid = 1'b0; wr_slot = '0; wr_pitch = '0; wr_instr = '0; wr_on = 1'b0;
    clear = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    step();
    cmp("reset type", int'(ptype), 3);
    cmp("reset instr", int'(itype), 0);
    cmp("reset valid", int'(pvalid), 0);
    cmp("reset ready", int'(wr_ready), 0);
    cmp("reset cursor", int'(cursor), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();

    // Staff line pixel, then out-of-area pixel
    px(100, 200);
    step();
    px(1300, 10);
    step();
    cmp("staff(100,200) type", int'(ptype), 1);
    cmp("staff(100,200) valid", int'(pvalid), 1);
    px(1400, 730);
    step();
    cmp("offscreen type", int'(ptype), 3);
    cmp("offscreen valid", int'(pvalid), 0);

    // Cursor: TEMPO=2, so one column per two ticks; 32 ticks wrap back to 0
    for (int t = 1; t <= 32; t++) begin
      tick_frame();
      cmp("cursor step", int'(cursor), (t / 2) % 16);
    end
    cmp("cursor wrap", int'(cursor), 0);
    repeat (3) tick_frame();
    cmp("cursor after 3", int'(cursor), 1);
    pause = 1'b1;
    repeat (4) begin
      tick_frame();
      cmp("cursor paused", int'(cursor), 1);
    end
    pause = 1'b0;

    // Write in blanking
    px(5, 720);
    step();
    write_note(3, 2, 2, 1);
    cmp("ready in blank", int'(wr_ready), 1);
    step();
    wr_valid = 1'b0;
    probe("note(106,216)", 106, 216, 0, 2);
    probe("edge(97,216)", 97, 216, 1, 0);

    // Write during active video is refused, then retried in blanking
    px(5, 100);
    step();
    write_note(5, 4, 1, 1);
    cmp("ready in active", int'(wr_ready), 0);
    step();
    wr_valid = 1'b0;
    probe("refused(170,232)", 170, 232, 1, 0);
    px(7, 720);
    step();
    write_note(5, 4, 1, 1);
    cmp("ready retry", int'(wr_ready), 1);
    step();
    wr_valid = 1'b0;
    probe("retry(170,232)", 170, 232, 0, 1);

    // Randomized scan, writes, clears, pauses and ticks
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)       px(0, 720);
      else if (r < 20) px(int'($urandom_range(1, 1400)), int'($urandom_range(720, 749)));
      else if (r < 65) px(int'($urandom_range(0, 540)), int'($urandom_range(180, 300)));
      else             px(int'($urandom_range(0, 1500)), int'($urandom_range(0, 749)));
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_slot  = 4'($urandom);
      wr_pitch = 4'($urandom);
      wr_instr = 2'($urandom);
      wr_on    = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 299) == 0);
      pause    = ($urandom_range(0, 9) == 0);
      step();
    end
    wr_valid = 1'b0; clear = 1'b0; pause = 1'b0;

    // Clear wins over a same-cycle write
    px(5, 720);
    step();
    write_note(3, 2, 2, 1);
    step();
    clear = 1'b1;
    write_note(8, 0, 0, 1);
    step();
    clear = 1'b0;
    wr_valid = 1'b0;
    probe("cleared(106,216)", 106, 216, 1, 0);
    probe("clrwrite(266,200)", 266, 200, 1, 0);
    probe("cursor after clear", m_cursor * 32 + 1, 232, 2, 0);

    // Reset mid-line with a note stored
    px(5, 720);
    step();
    write_note(3, 2, 2, 1);
    step();
    wr_valid = 1'b0;
    px(106, 216);
    step();
    px(110, 216);
    step();
    cmp("pre-reset note", int'(ptype), 0);
    rst = 1'b1;
    #1;
    cmp("midreset type", int'(ptype), 3);
    cmp("midreset instr", int'(itype), 0);
    cmp("midreset valid", int'(pvalid), 0);
    cmp("midreset ready", int'(wr_ready), 0);
    cmp("midreset cursor", int'(cursor), 0);
    step();
    step();
    rst = 1'b0;
    probe("post-reset(106,216)", 106, 216, 1, 0);
    probe("post-reset cursor px", 0, 216, 2, 0);
    cmp("post-reset cursor", int'(cursor), 0);

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
